// File: rtl/pb_soc_regfile_pkg.sv
// pb_soc_regfile_pkg
// Shared definitions for the parametrised Picoblaze SoC register file.
//   - Offset constants for every register group (relative to BASE_ADDR).
//   - Lock key constants for the two-step unlock sequence.
//   - Lock FSM state type; its encoding is also what a LOCK read returns.
// Optional feature macro used by the register file: PB_SOC_REGFILE_LOCK_EN.
package pb_soc_regfile_pkg;

  localparam logic [7:0] OFF_CTRL         = 8'h00;
  localparam logic [7:0] OFF_IRQ_STATUS   = 8'h01;
  localparam logic [7:0] OFF_IRQ_MASK     = 8'h02;
  localparam logic [7:0] OFF_IRQ_RAW      = 8'h03;
  localparam logic [7:0] OFF_IRQ_PEND     = 8'h04;
  localparam logic [7:0] OFF_LOCK         = 8'h05;
  localparam logic [7:0] OFF_SCRATCH_BASE = 8'h10;
  localparam logic [7:0] OFF_EXT_BASE     = 8'h20;

  localparam logic [7:0] KEY_A = 8'hA5;
  localparam logic [7:0] KEY_B = 8'h5A;

  // Encoding is software visible through a LOCK read.
  typedef enum logic [1:0] {
    LOCK_LOCKED   = 2'd0,
    LOCK_KEY1     = 2'd1,
    LOCK_UNLOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/pb_soc_irq_capture.sv
// pb_soc_irq_capture
// Interrupt capture block: rising-edge detection on the raw sources, a
// write-1-to-clear status register, an interrupt mask (1 = masked) and the
// registered combined interrupt request.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   irq_src      raw interrupt sources (synchronous to clk)
//   status_w1c   W1C write strobe for the status register
//   w1c_bits     bits to clear when status_w1c is high
//   clear_all    clear every status bit this cycle
//   mask_we      mask register write strobe
//   mask_wdata   new mask value
//   enable       global interrupt enable
//   status       captured status
//   mask         current mask
//   pending      status & ~mask
//   irq_req      registered combined interrupt
module pb_soc_irq_capture
  import pb_soc_regfile_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               status_w1c,
  input  logic [NUM_IRQ-1:0] w1c_bits,
  input  logic               clear_all,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               enable,
  output logic [NUM_IRQ-1:0] status,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic               irq_req
);

  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] status_next;

  // Clearing is applied first and the new edges ORed in afterwards, so a
  // set arriving in the same cycle as a clear always wins.
  always_comb begin
    rise = irq_src & ~prev;
    clr  = '0;
    if (status_w1c) clr = w1c_bits;
    if (clear_all)  clr = '1;
    status_next = (status & ~clr) | rise;
  end

  assign pending = status & ~mask;

  // prev tracks irq_src even in reset so a source that is already high when
  // reset is released is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= irq_src;
      status  <= '0;
      mask    <= '1;
      irq_req <= 1'b0;
    end else begin
      prev    <= irq_src;
      status  <= status_next;
      if (mask_we) mask <= mask_wdata;
      irq_req <= enable & (|pending);
    end
  end

endmodule

// File: rtl/pb_soc_regfile_param.sv
// pb_soc_regfile_param
// Parametrised Picoblaze port-bus register file: control, interrupt
// status/mask/raw/pending, scratch registers and NUM_EXT external channels
// with one-cycle read/write strobes.
// Optional feature macro: PB_SOC_REGFILE_LOCK_EN adds a LOCK register with a
// two-key unlock FSM protecting CTRL, IRQ_MASK and the scratch registers.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   addr_i         port address (offset = addr_i - BASE_ADDR)
//   data_i         write data
//   rd_i, wr_i     single-cycle read / write strobes
//   data_o         registered read data, held until the next read
//   rd_valid_o     one-cycle pulse with each read result
//   err_o          pulse on unmapped or disallowed access
//   irq_i          raw interrupt sources
//   irq_o          registered combined interrupt
//   ext_wdata_o    last data written to any external channel
//   ext_wr_o       one-hot write pulse per external channel
//   ext_rd_o       one-hot read pulse per external channel
//   ext_rdata_i    external read data, channel k at [k*DATA_W +: DATA_W]
module pb_soc_regfile_param
  import pb_soc_regfile_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          NUM_IRQ     = 8,
  parameter int          NUM_SCRATCH = 4,
  parameter int          NUM_EXT     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      rd_i,
  input  logic                      wr_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      rd_valid_o,
  output logic                      err_o,
  input  logic [NUM_IRQ-1:0]        irq_i,
  output logic                      irq_o,
  output logic [DATA_W-1:0]         ext_wdata_o,
  output logic [NUM_EXT-1:0]        ext_wr_o,
  output logic [NUM_EXT-1:0]        ext_rd_o,
  input  logic [NUM_EXT*DATA_W-1:0] ext_rdata_i
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] scr_rel;
  logic [ADDR_W-1:0] ext_rel;

  logic hit_ctrl, hit_status, hit_mask, hit_raw, hit_pend, hit_lock;
  logic hit_scr, hit_ext;
  logic unlocked;
  logic [DATA_W-1:0] lock_rdata;

  logic [NUM_EXT-1:0] ext_onehot;
  logic [DATA_W-1:0]  rd_value;
  logic               rd_mapped;
  logic               wr_allowed;
  logic               wr_en;

  logic               gie;
  logic [DATA_W-1:0]  scratch [NUM_SCRATCH];

  logic [NUM_IRQ-1:0] irq_status;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [NUM_IRQ-1:0] irq_pend;

  // Address decode, all relative to BASE_ADDR (wraps modulo 2^ADDR_W).
  assign offset  = addr_i - BASE;
  assign scr_rel = offset - ADDR_W'(OFF_SCRATCH_BASE);
  assign ext_rel = offset - ADDR_W'(OFF_EXT_BASE);

  assign hit_ctrl   = (offset == ADDR_W'(OFF_CTRL));
  assign hit_status = (offset == ADDR_W'(OFF_IRQ_STATUS));
  assign hit_mask   = (offset == ADDR_W'(OFF_IRQ_MASK));
  assign hit_raw    = (offset == ADDR_W'(OFF_IRQ_RAW));
  assign hit_pend   = (offset == ADDR_W'(OFF_IRQ_PEND));
  assign hit_scr    = (offset >= ADDR_W'(OFF_SCRATCH_BASE)) &&
                      (scr_rel < ADDR_W'(NUM_SCRATCH));
  assign hit_ext    = (offset >= ADDR_W'(OFF_EXT_BASE)) &&
                      (ext_rel < ADDR_W'(NUM_EXT));

`ifdef PB_SOC_REGFILE_LOCK_EN
  lock_state_t lock_state, lock_next;

  assign hit_lock   = (offset == ADDR_W'(OFF_LOCK));
  assign unlocked   = (lock_state == LOCK_UNLOCKED);
  assign lock_rdata = DATA_W'(lock_state);

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_state <= LOCK_LOCKED;
    else       lock_state <= lock_next;
  end

  // In KEY1 any write other than the second key, to any offset, aborts the
  // sequence; this stops a stray write from sitting between the two keys.
  always_comb begin
    lock_next = lock_state;
    if (wr_i) begin
      unique case (lock_state)
        LOCK_LOCKED:   if (hit_lock && data_i == DATA_W'(KEY_A)) lock_next = LOCK_KEY1;
        LOCK_KEY1:     lock_next = (hit_lock && data_i == DATA_W'(KEY_B)) ? LOCK_UNLOCKED : LOCK_LOCKED;
        LOCK_UNLOCKED: if (hit_lock) lock_next = LOCK_LOCKED;
        default:       lock_next = LOCK_LOCKED;
      endcase
    end
  end
`else
  // Without the lock feature the LOCK offset is simply unmapped.
  assign hit_lock   = 1'b0;
  assign unlocked   = 1'b1;
  assign lock_rdata = '0;
`endif

  // Read mux and external-channel select; reads see pre-write values since
  // all registers update on the same edge that captures data_o.
  always_comb begin
    rd_value   = '0;
    rd_mapped  = 1'b1;
    ext_onehot = '0;
    for (int k = 0; k < NUM_EXT; k++) begin
      if (hit_ext && ext_rel == ADDR_W'(k)) ext_onehot[k] = 1'b1;
    end
    if (hit_ctrl)        rd_value = DATA_W'(gie);
    else if (hit_status) rd_value = DATA_W'(irq_status);
    else if (hit_mask)   rd_value = DATA_W'(irq_mask);
    else if (hit_raw)    rd_value = DATA_W'(irq_i);
    else if (hit_pend)   rd_value = DATA_W'(irq_pend);
    else if (hit_lock)   rd_value = lock_rdata;
    else if (hit_scr) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scr_rel == ADDR_W'(i)) rd_value = scratch[i];
      end
    end else if (hit_ext) begin
      for (int k = 0; k < NUM_EXT; k++) begin
        if (ext_onehot[k]) rd_value = ext_rdata_i[k*DATA_W +: DATA_W];
      end
    end else begin
      rd_mapped = 1'b0;
    end
  end

  // IRQ_STATUS W1C, ext writes and LOCK itself are never protected.
  assign wr_allowed = hit_status | hit_ext | hit_lock |
                      ((hit_ctrl | hit_mask | hit_scr) & unlocked);
  assign wr_en      = wr_i & wr_allowed;

  pb_soc_irq_capture #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk        (clk_i),
    .rst        (rst_i),
    .irq_src    (irq_i),
    .status_w1c (wr_en & hit_status),
    .w1c_bits   (data_i[NUM_IRQ-1:0]),
    .clear_all  (wr_en & hit_ctrl & data_i[1]),
    .mask_we    (wr_en & hit_mask),
    .mask_wdata (data_i[NUM_IRQ-1:0]),
    .enable     (gie),
    .status     (irq_status),
    .mask       (irq_mask),
    .pending    (irq_pend),
    .irq_req    (irq_o)
  );

  // Bus response, strobes and register writes. CTRL only stores the enable
  // bit; the clear-all bit acts as a pulse and is never stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= '0;
      rd_valid_o  <= 1'b0;
      err_o       <= 1'b0;
      ext_wr_o    <= '0;
      ext_rd_o    <= '0;
      ext_wdata_o <= '0;
      gie         <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      rd_valid_o <= rd_i;
      if (rd_i) data_o <= rd_value;
      err_o    <= (rd_i & ~rd_mapped) | (wr_i & ~wr_allowed);
      ext_wr_o <= wr_i ? ext_onehot : '0;
      ext_rd_o <= rd_i ? ext_onehot : '0;
      if (wr_i & hit_ext) ext_wdata_o <= data_i;
      if (wr_en & hit_ctrl) gie <= data_i[0];
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_en && hit_scr && scr_rel == ADDR_W'(i)) scratch[i] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_pb_soc_regfile_param.sv
// tb_pb_soc_regfile_param
// Self-checking bench for pb_soc_regfile_param (default parameters).
// A behavioural register-file model tracks the expected outputs for every
// clock edge; directed scenario tasks and a randomized access loop compare
// the design against it. Lock scenarios are built when
// PB_SOC_REGFILE_LOCK_EN is defined.
module tb_pb_soc_regfile_param;

`ifdef PB_SOC_REGFILE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  addr_i;
  logic [7:0]  data_i;
  logic        rd_i;
  logic        wr_i;
  logic [7:0]  data_o;
  logic        rd_valid_o;
  logic        err_o;
  logic [7:0]  irq_i;
  logic        irq_o;
  logic [7:0]  ext_wdata_o;
  logic [1:0]  ext_wr_o;
  logic [1:0]  ext_rd_o;
  logic [15:0] ext_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  pb_soc_regfile_param dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .rd_i        (rd_i),
    .wr_i        (wr_i),
    .data_o      (data_o),
    .rd_valid_o  (rd_valid_o),
    .err_o       (err_o),
    .irq_i       (irq_i),
    .irq_o       (irq_o),
    .ext_wdata_o (ext_wdata_o),
    .ext_wr_o    (ext_wr_o),
    .ext_rd_o    (ext_rd_o),
    .ext_rdata_i (ext_rdata_i)
  );

  // Behavioural model state (values after the most recent clock edge).
  bit         m_gie;
  logic [7:0] m_status, m_mask, m_prev;
  logic [7:0] m_scr [4];
  int         m_lock;
  logic [7:0] exp_data, exp_wdata;
  bit         exp_rdv, exp_err, exp_irq;
  logic [1:0] exp_ext_wr, exp_ext_rd;

  function automatic void model_reset(input logic [7:0] irq);
    m_gie = 0; m_status = 8'h00; m_mask = 8'hFF; m_prev = irq; m_lock = 0;
    for (int i = 0; i < 4; i++) m_scr[i] = 8'h00;
    exp_data = 8'h00; exp_wdata = 8'h00; exp_rdv = 0; exp_err = 0; exp_irq = 0;
    exp_ext_wr = 2'b00; exp_ext_rd = 2'b00;
  endfunction

  function automatic void model_read(input int off, input logic [7:0] irq, input logic [15:0] ext,
                                     output logic [7:0] rv, output bit mapped);
    mapped = 1; rv = 8'h00;
    if (off == 0)                  rv = {7'b0, m_gie};
    else if (off == 1)             rv = m_status;
    else if (off == 2)             rv = m_mask;
    else if (off == 3)             rv = irq;
    else if (off == 4)             rv = m_status & ~m_mask;
    else if (off == 5 && LOCK_EN)  rv = 8'(m_lock);
    else if (off >= 16 && off < 20) rv = m_scr[off-16];
    else if (off == 32 || off == 33) rv = ext[(off-32)*8 +: 8];
    else mapped = 0;
  endfunction

  function automatic bit model_write_ok(input int off);
    bit prot = !LOCK_EN || (m_lock == 2);
    if (off == 0 || off == 2 || (off >= 16 && off < 20)) return prot;
    if (off == 1 || off == 32 || off == 33) return 1;
    if (off == 5) return LOCK_EN;
    return 0;
  endfunction

  // One clock edge: apply inputs (we are at a negedge), advance the model,
  // then return at the following negedge where outputs are sampled.
  task automatic drive_cycle(input bit rst, input bit rd, input bit wr, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] irq);
    logic [7:0] rv, clr;
    bit mapped, okw;
    int off;
    rst_i = rst; rd_i = rd; wr_i = wr; addr_i = a; data_i = d; irq_i = irq;
    off = int'(a);
    if (rst) begin
      model_reset(irq);
    end else begin
      model_read(off, irq, ext_rdata_i, rv, mapped);
      okw = model_write_ok(off);
      exp_rdv = rd;
      if (rd) exp_data = rv;
      exp_err = (rd && !mapped) || (wr && !okw);
      exp_ext_wr = 2'b00; exp_ext_rd = 2'b00;
      if (off == 32 || off == 33) begin
        if (wr) begin exp_ext_wr = 2'(1 << (off-32)); exp_wdata = d; end
        if (rd) exp_ext_rd = 2'(1 << (off-32));
      end
      exp_irq = m_gie && ((m_status & ~m_mask) != 8'h00);
      clr = 8'h00;
      if (wr && okw) begin
        if (off == 0) begin m_gie = d[0]; if (d[1]) clr = 8'hFF; end
        else if (off == 1) clr = d;
        else if (off == 2) m_mask = d;
        else if (off >= 16 && off < 20) m_scr[off-16] = d;
      end
      if (LOCK_EN && wr) begin
        if (m_lock == 1)   m_lock = (off == 5 && d == 8'h5A) ? 2 : 0;
        else if (off == 5) m_lock = (m_lock == 0 && d == 8'hA5) ? 1 : 0;
      end
      m_status = (m_status & ~clr) | (irq & ~m_prev);
      m_prev = irq;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, 8'h00, 8'h00, 8'h01);
    drive_cycle(1, 0, 0, 8'h00, 8'h00, 8'h01);
    n_checks++; if (data_o !== 8'h00 || rd_valid_o !== 1'b0 || err_o !== 1'b0)
      $display("[TB] FAIL reset_bus: got data=%h rdv=%b err=%b want 00/0/0", data_o, rd_valid_o, err_o); else n_pass++;
    n_checks++; if (ext_wr_o !== 2'b00 || ext_rd_o !== 2'b00 || ext_wdata_o !== 8'h00)
      $display("[TB] FAIL reset_ext: got wr=%b rd=%b wdata=%h want 00/00/00", ext_wr_o, ext_rd_o, ext_wdata_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h01, 8'h00, 8'h01);
    n_checks++; if (data_o !== 8'h00 || rd_valid_o !== 1'b1)
      $display("[TB] FAIL reset_status: got %h rdv=%b want 00 rdv=1", data_o, rd_valid_o); else n_pass++;
    n_checks++; if (irq_o !== 1'b0) $display("[TB] FAIL reset_irq: got %b want 0", irq_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h02, 8'h00, 8'h01);
    n_checks++; if (data_o !== 8'hFF) $display("[TB] FAIL reset_mask: got %h want ff", data_o); else n_pass++;
    n_checks++; if (rd_valid_o !== 1'b1) $display("[TB] FAIL reset_rdvalid: got %b want 1", rd_valid_o); else n_pass++;
  endtask

  task automatic test_irq();
    drive_cycle(0, 0, 1, 8'h02, 8'hFE, 8'h00);
    drive_cycle(0, 0, 1, 8'h00, 8'h01, 8'h00);
    drive_cycle(0, 0, 0, 8'h00, 8'h00, 8'h01);
    n_checks++; if (irq_o !== 1'b0) $display("[TB] FAIL irq_early: got %b want 0", irq_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h01, 8'h00, 8'h01);
    n_checks++; if (irq_o !== 1'b1) $display("[TB] FAIL irq_rise: got %b want 1", irq_o); else n_pass++;
    n_checks++; if (data_o !== 8'h01) $display("[TB] FAIL irq_status: got %h want 01", data_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h04, 8'h00, 8'h00);
    n_checks++; if (data_o !== exp_data) $display("[TB] FAIL irq_pend: got %h want %h", data_o, exp_data); else n_pass++;
    drive_cycle(0, 0, 1, 8'h01, 8'h01, 8'h00);
    n_checks++; if (irq_o !== 1'b1) $display("[TB] FAIL irq_hold: got %b want 1", irq_o); else n_pass++;
    drive_cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
    n_checks++; if (irq_o !== 1'b0) $display("[TB] FAIL irq_drop: got %b want 0", irq_o); else n_pass++;
  endtask

  task automatic test_set_wins();
    drive_cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
    drive_cycle(0, 0, 1, 8'h01, 8'h08, 8'h08);
    drive_cycle(0, 1, 0, 8'h01, 8'h00, 8'h08);
    n_checks++; if (data_o[3] !== 1'b1 || data_o !== exp_data)
      $display("[TB] FAIL set_wins: got %h want %h (bit3 set)", data_o, exp_data); else n_pass++;
    drive_cycle(0, 0, 1, 8'h00, 8'h03, 8'h08);
    drive_cycle(0, 1, 0, 8'h01, 8'h00, 8'h08);
    n_checks++; if (data_o !== 8'h00) $display("[TB] FAIL clear_all: got %h want 00", data_o); else n_pass++;
  endtask

  task automatic test_ext();
    ext_rdata_i = 16'hC477;
    drive_cycle(0, 0, 1, 8'h21, 8'h3C, 8'h00);
    n_checks++; if (ext_wr_o !== 2'b10) $display("[TB] FAIL ext_wr: got %b want 10", ext_wr_o); else n_pass++;
    n_checks++; if (ext_wdata_o !== 8'h3C) $display("[TB] FAIL ext_wdata: got %h want 3c", ext_wdata_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h20, 8'h00, 8'h00);
    n_checks++; if (ext_wr_o !== 2'b00) $display("[TB] FAIL ext_wr_len: got %b want 00", ext_wr_o); else n_pass++;
    n_checks++; if (data_o !== 8'h77 || ext_rd_o !== 2'b01)
      $display("[TB] FAIL ext_rd: got data=%h rd=%b want 77/01", data_o, ext_rd_o); else n_pass++;
    drive_cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
    n_checks++; if (ext_rd_o !== 2'b00 || ext_wdata_o !== 8'h3C)
      $display("[TB] FAIL ext_idle: got rd=%b wdata=%h want 00/3c", ext_rd_o, ext_wdata_o); else n_pass++;
  endtask

  task automatic test_errors();
    drive_cycle(0, 1, 0, 8'h0F, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h00 || err_o !== 1'b1 || rd_valid_o !== 1'b1)
      $display("[TB] FAIL err_unmapped_rd: got data=%h err=%b rdv=%b want 00/1/1", data_o, err_o, rd_valid_o); else n_pass++;
    drive_cycle(0, 0, 1, 8'h03, 8'hFF, 8'h00);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL err_ro_wr: got %b want 1", err_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h02, 8'h00, 8'h00);
    n_checks++; if (err_o !== 1'b0 || data_o !== exp_data)
      $display("[TB] FAIL err_no_change: got err=%b mask=%h want 0/%h", err_o, data_o, exp_data); else n_pass++;
`ifndef PB_SOC_REGFILE_LOCK_EN
    drive_cycle(0, 1, 0, 8'h05, 8'h00, 8'h00);
    n_checks++; if (err_o !== 1'b1 || data_o !== 8'h00)
      $display("[TB] FAIL lock_unmapped: got err=%b data=%h want 1/00", err_o, data_o); else n_pass++;
`endif
  endtask

  task automatic test_same_cycle();
    drive_cycle(0, 0, 1, 8'h10, 8'h11, 8'h00);
    drive_cycle(0, 1, 1, 8'h10, 8'h55, 8'h00);
    n_checks++; if (data_o !== 8'h11) $display("[TB] FAIL rw_old: got %h want 11", data_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h10, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h55) $display("[TB] FAIL rw_new: got %h want 55", data_o); else n_pass++;
  endtask

`ifdef PB_SOC_REGFILE_LOCK_EN
  task automatic test_lock();
    drive_cycle(0, 0, 1, 8'h10, 8'h99, 8'h00);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL lock_drop_err: got %b want 1", err_o); else n_pass++;
    drive_cycle(0, 1, 1, 8'h05, 8'hA5, 8'h00);
    n_checks++; if (data_o !== 8'h00) $display("[TB] FAIL lock_rd0: got %h want 00", data_o); else n_pass++;
    drive_cycle(0, 1, 1, 8'h05, 8'h5A, 8'h00);
    n_checks++; if (data_o !== 8'h01) $display("[TB] FAIL lock_rd1: got %h want 01", data_o); else n_pass++;
    drive_cycle(0, 1, 1, 8'h10, 8'h99, 8'h00);
    n_checks++; if (data_o !== 8'h00 || err_o !== 1'b0)
      $display("[TB] FAIL lock_scr_old: got data=%h err=%b want 00/0", data_o, err_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h05, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h02) $display("[TB] FAIL lock_rd2: got %h want 02", data_o); else n_pass++;
    drive_cycle(0, 1, 1, 8'h05, 8'h00, 8'h00);
    drive_cycle(0, 0, 1, 8'h05, 8'hA5, 8'h00);
    drive_cycle(0, 0, 1, 8'h10, 8'h42, 8'h00);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL lock_key1_err: got %b want 1", err_o); else n_pass++;
    drive_cycle(0, 0, 1, 8'h05, 8'h5A, 8'h00);
    drive_cycle(0, 1, 0, 8'h05, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h00) $display("[TB] FAIL lock_abort: got %h want 00", data_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h10, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h99) $display("[TB] FAIL lock_scr_keep: got %h want 99", data_o); else n_pass++;
    drive_cycle(0, 0, 1, 8'h05, 8'hA5, 8'h00);
    drive_cycle(0, 0, 1, 8'h05, 8'h5A, 8'h00);
  endtask
`endif

  task automatic test_mid_reset();
    drive_cycle(1, 1, 1, 8'h20, 8'hEE, 8'h00);
    n_checks++; if (ext_wr_o !== 2'b00 || ext_rd_o !== 2'b00 || rd_valid_o !== 1'b0 || ext_wdata_o !== 8'h00)
      $display("[TB] FAIL mid_reset: got wr=%b rd=%b rdv=%b wdata=%h want 00/00/0/00",
               ext_wr_o, ext_rd_o, rd_valid_o, ext_wdata_o); else n_pass++;
    drive_cycle(0, 1, 0, 8'h10, 8'h00, 8'h00);
    n_checks++; if (data_o !== 8'h00) $display("[TB] FAIL mid_reset_scr: got %h want 00", data_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] offs [16];
    logic [7:0] irq;
    offs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 8'h10,
             8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h21, 8'h22, 8'hFF};
    irq = 8'h00;
    for (int n = 0; n < 400; n++) begin
      bit rst, rd, wr;
      logic [7:0] a, d;
      rst = ($urandom_range(0, 79) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 2) == 0);
      a   = offs[$urandom_range(0, 15)];
      d   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      ext_rdata_i = 16'($urandom);
      drive_cycle(rst, rd, wr, a, d, irq);
      n_checks++; if (data_o !== exp_data) $display("[TB] FAIL rand_data @%0d: got %h want %h", n, data_o, exp_data); else n_pass++;
      n_checks++; if (rd_valid_o !== exp_rdv) $display("[TB] FAIL rand_rdv @%0d: got %b want %b", n, rd_valid_o, exp_rdv); else n_pass++;
      n_checks++; if (err_o !== exp_err) $display("[TB] FAIL rand_err @%0d: got %b want %b", n, err_o, exp_err); else n_pass++;
      n_checks++; if (irq_o !== exp_irq) $display("[TB] FAIL rand_irq @%0d: got %b want %b", n, irq_o, exp_irq); else n_pass++;
      n_checks++; if (ext_wr_o !== exp_ext_wr) $display("[TB] FAIL rand_extwr @%0d: got %b want %b", n, ext_wr_o, exp_ext_wr); else n_pass++;
      n_checks++; if (ext_rd_o !== exp_ext_rd) $display("[TB] FAIL rand_extrd @%0d: got %b want %b", n, ext_rd_o, exp_ext_rd); else n_pass++;
      n_checks++; if (ext_wdata_o !== exp_wdata) $display("[TB] FAIL rand_wdata @%0d: got %h want %h", n, ext_wdata_o, exp_wdata); else n_pass++;
    end
  endtask

  initial begin
    rst_i = 1'b1; rd_i = 1'b0; wr_i = 1'b0; addr_i = 8'h00; data_i = 8'h00;
    irq_i = 8'h01; ext_rdata_i = 16'h0000;
    model_reset(8'h01);
    @(negedge clk_i);
    test_reset();
`ifdef PB_SOC_REGFILE_LOCK_EN
    test_lock();
`endif
    test_irq();
    test_set_wins();
    test_ext();
    test_errors();
    test_same_cycle();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
